// File: rtl/fwd_hazard_unit_if.sv
// Purpose : bundle of ID-stage request, stage result and resolved-operand signals for fwd_hazard_unit.
// Latency : pure wiring; no storage.
// Backpr. : stall travels back to the pipeline control on this bundle.
//
// Modports:
//   master - pipeline side; drives advance/flush/id_*/stage_data/rf_data, receives operands and stall.
//   slave  - forwarding unit side; the mirror image.
// Optional: FWD_HAZARD_STATS_EN adds the fwd_count / stall_count observation outputs.
interface fwd_hazard_unit_if #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 3,
  parameter int NUM_SRC    = 2,
  parameter int FWD_DEPTH  = 3
);
  localparam int SEL_W = $clog2(FWD_DEPTH + 1);

  logic                            advance;
  logic                            flush;
  logic                            id_valid;
  logic [NUM_SRC*REG_ADDR_W-1:0]   id_src;
  logic [NUM_SRC-1:0]              id_src_used;
  logic                            id_wr_en;
  logic [REG_ADDR_W-1:0]           id_dest;
  logic                            id_is_load;
  logic [FWD_DEPTH*DATA_W-1:0]     stage_data;
  logic [NUM_SRC*DATA_W-1:0]       rf_data;
  logic [NUM_SRC*DATA_W-1:0]       opnd_data;
  logic [NUM_SRC*SEL_W-1:0]        fwd_sel;
  logic                            stall;
`ifdef FWD_HAZARD_STATS_EN
  logic [15:0]                     fwd_count;
  logic [15:0]                     stall_count;
`endif

  modport master (
    output advance, flush, id_valid, id_src, id_src_used, id_wr_en, id_dest, id_is_load,
    output stage_data, rf_data,
`ifdef FWD_HAZARD_STATS_EN
    input  fwd_count, stall_count,
`endif
    input  opnd_data, fwd_sel, stall
  );

  modport slave (
    input  advance, flush, id_valid, id_src, id_src_used, id_wr_en, id_dest, id_is_load,
    input  stage_data, rf_data,
`ifdef FWD_HAZARD_STATS_EN
    output fwd_count, stall_count,
`endif
    output opnd_data, fwd_sel, stall
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Purpose : operand forwarding and load-use interlock driven by a scoreboard of in-flight destination tags.
// Latency : operand resolution and stall are combinational; scoreboard shifts one entry per advance.
// Backpr. : raises stall while the youngest producer of a read operand is a load not yet at LOAD_LAT.
//
// Ports:
//   clk, rst_n   - pipeline clock, asynchronous active-low reset.
//   bus (slave)  - advance/flush strobes, ID-stage request (valid, sources, use mask, dest, load flag),
//                  per-stage results, regfile read data; returns opnd_data, fwd_sel and stall.
//   fwd_sel per operand: 0 = regfile, k+1 = scoreboard entry k (0 = EX ... FWD_DEPTH-1 = WB).
// Optional: define FWD_HAZARD_STATS_EN for saturating 16-bit fwd_count / stall_count outputs.
module fwd_hazard_unit #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 3,
  parameter int NUM_SRC    = 2,
  parameter int FWD_DEPTH  = 3,
  parameter int LOAD_LAT   = 2
) (
  input logic clk,
  input logic rst_n,
  fwd_hazard_unit_if.slave bus
);
  localparam int SEL_W = $clog2(FWD_DEPTH + 1);

  // Scoreboard: one entry per back-end stage, entry 0 is the youngest (EX).
  logic [FWD_DEPTH-1:0]  valid_q;
  logic [FWD_DEPTH-1:0]  wr_q;
  logic [FWD_DEPTH-1:0]  ld_q;
  logic [REG_ADDR_W-1:0] dest_q [FWD_DEPTH];

  // Entry k can supply data this cycle: ALU results always, load results from LOAD_LAT on.
  logic [FWD_DEPTH-1:0]  avail;

  logic [NUM_SRC*DATA_W-1:0] opnd_c;
  logic [NUM_SRC*SEL_W-1:0]  sel_c;
  logic                      stall_raw;
  logic                      stall_c;
  logic                      hit_done;

  for (genvar k = 0; k < FWD_DEPTH; k++) begin : g_avail
    if (k >= LOAD_LAT) begin : g_late
      assign avail[k] = 1'b1;
    end else begin : g_early
      assign avail[k] = ~ld_q[k];
    end
  end

  // Resolve every operand against the scoreboard. The first hit scanning from
  // entry 0 is the youngest producer; older matches, WB included, are shadowed.
  // An unavailable winner keeps the regfile path selected so the output stays
  // deterministic while the instruction is held.
  always_comb begin
    opnd_c    = bus.rf_data;
    sel_c     = '0;
    stall_raw = 1'b0;
    hit_done  = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      hit_done = 1'b0;
      for (int k = 0; k < FWD_DEPTH; k++) begin
        if (!hit_done && bus.id_valid && bus.id_src_used[i] && valid_q[k] && wr_q[k] &&
            (dest_q[k] == bus.id_src[i*REG_ADDR_W +: REG_ADDR_W])) begin
          hit_done = 1'b1;
          if (avail[k]) begin
            sel_c[i*SEL_W +: SEL_W]    = SEL_W'(k + 1);
            opnd_c[i*DATA_W +: DATA_W] = bus.stage_data[k*DATA_W +: DATA_W];
          end else begin
            stall_raw = 1'b1;
          end
        end
      end
    end
  end

  // A flushed ID instruction is discarded anyway, so it must not hold the front end.
  assign stall_c = stall_raw & ~bus.flush;

  assign bus.opnd_data = opnd_c;
  assign bus.fwd_sel   = sel_c;
  assign bus.stall     = stall_c;

  // Scoreboard shift. On a stall the ID instruction stays put and a bubble
  // enters EX, so the producer keeps moving toward LOAD_LAT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      wr_q    <= '0;
      ld_q    <= '0;
      for (int k = 0; k < FWD_DEPTH; k++) dest_q[k] <= '0;
    end else if (bus.flush) begin
      valid_q <= '0;
      wr_q    <= '0;
      ld_q    <= '0;
      for (int k = 0; k < FWD_DEPTH; k++) dest_q[k] <= '0;
    end else if (bus.advance) begin
      for (int k = FWD_DEPTH - 1; k >= 1; k--) begin
        valid_q[k] <= valid_q[k-1];
        wr_q[k]    <= wr_q[k-1];
        ld_q[k]    <= ld_q[k-1];
        dest_q[k]  <= dest_q[k-1];
      end
      valid_q[0] <= bus.id_valid & ~stall_c;
      wr_q[0]    <= bus.id_wr_en;
      ld_q[0]    <= bus.id_is_load;
      dest_q[0]  <= bus.id_dest;
    end
  end

`ifdef FWD_HAZARD_STATS_EN
  logic        any_fwd;
  logic [15:0] fwd_cnt_q;
  logic [15:0] stall_cnt_q;

  assign any_fwd = |sel_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else if (bus.advance) begin
      if (any_fwd && !stall_c && (fwd_cnt_q != 16'hFFFF)) fwd_cnt_q <= fwd_cnt_q + 16'd1;
      if (stall_c && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign bus.fwd_count   = fwd_cnt_q;
  assign bus.stall_count = stall_cnt_q;
`endif
endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;
  localparam logic [47:0] SD = 48'h3333_2222_1111;
  localparam logic [31:0] RF = 32'hBBBB_AAAA;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit_if #(.DATA_W(16), .REG_ADDR_W(3), .NUM_SRC(2), .FWD_DEPTH(3)) bus ();

  fwd_hazard_unit #(.DATA_W(16), .REG_ADDR_W(3), .NUM_SRC(2), .FWD_DEPTH(3), .LOAD_LAT(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string       nm;
    logic        adv;
    logic        fl;
    logic        vld;
    logic [5:0]  src;
    logic [1:0]  used;
    logic        wr;
    logic [2:0]  dest;
    logic        ld;
    logic [47:0] sd;
    logic        exp_stall;
    logic [3:0]  exp_sel;
    logic [31:0] exp_opnd;
  } vec_t;

  vec_t vec [18];

  function automatic vec_t mk(string nm, logic adv, logic fl, logic vld, logic [5:0] src,
                              logic [1:0] used, logic wr, logic [2:0] dest, logic ld,
                              logic [47:0] sd, logic es, logic [3:0] esel, logic [31:0] eop);
    vec_t v;
    v.nm = nm; v.adv = adv; v.fl = fl; v.vld = vld; v.src = src; v.used = used;
    v.wr = wr; v.dest = dest; v.ld = ld; v.sd = sd;
    v.exp_stall = es; v.exp_sel = esel; v.exp_opnd = eop;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  task automatic drive(input logic adv, input logic fl, input logic vld, input logic [5:0] src,
                       input logic [1:0] used, input logic wr, input logic [2:0] dest,
                       input logic ld, input logic [47:0] sd);
    bus.advance     = adv;
    bus.flush       = fl;
    bus.id_valid    = vld;
    bus.id_src      = src;
    bus.id_src_used = used;
    bus.id_wr_en    = wr;
    bus.id_dest     = dest;
    bus.id_is_load  = ld;
    bus.stage_data  = sd;
    bus.rf_data     = RF;
  endtask

  task automatic chk_out(input string nm, input logic es, input logic [3:0] esel, input logic [31:0] eop);
    chk({nm, ".stall"}, {63'd0, bus.stall}, {63'd0, es});
    chk({nm, ".sel"},   {60'd0, bus.fwd_sel}, {60'd0, esel});
    chk({nm, ".opnd"},  {32'd0, bus.opnd_data}, {32'd0, eop});
  endtask

  initial begin
    // src packing is {src1, src0}; fwd_sel is {sel1, sel0}; data is {op1, op0}.
    vec[0]  = mk("empty",      1,0,1,{3'd2,3'd1},2'b11,0,3'd0,0,SD,0,4'b0000,RF);
    vec[1]  = mk("alu_issue",  1,0,1,{3'd2,3'd1},2'b11,1,3'd3,0,SD,0,4'b0000,RF);
    vec[2]  = mk("ex_fwd_dup", 1,0,1,{3'd3,3'd3},2'b11,0,3'd0,0,48'h3333_2222_1234,0,4'b0101,32'h1234_1234);
    vec[3]  = mk("mem_fwd",    1,0,1,{3'd5,3'd3},2'b01,1,3'd3,0,SD,0,4'b0010,32'hBBBB_2222);
    vec[4]  = mk("youngest",   1,0,1,{3'd5,3'd3},2'b01,0,3'd0,0,48'h0002_2222_0001,0,4'b0001,32'hBBBB_0001);
    vec[5]  = mk("hold_a",     0,0,1,{3'd5,3'd3},2'b01,0,3'd0,0,SD,0,4'b0010,32'hBBBB_2222);
    vec[6]  = mk("hold_b",     0,0,1,{3'd3,3'd1},2'b11,0,3'd0,0,SD,0,4'b1000,32'h2222_AAAA);
    vec[7]  = mk("unused",     1,0,1,{3'd3,3'd3},2'b00,0,3'd0,0,SD,0,4'b0000,RF);
    vec[8]  = mk("wb_fwd",     1,0,1,{3'd5,3'd3},2'b01,1,3'd4,1,SD,0,4'b0011,32'hBBBB_3333);
    vec[9]  = mk("ld_use_1",   1,0,1,{3'd5,3'd4},2'b01,1,3'd6,0,SD,1,4'b0000,RF);
    vec[10] = mk("ld_use_2",   1,0,1,{3'd5,3'd4},2'b01,1,3'd6,0,SD,1,4'b0000,RF);
    vec[11] = mk("ld_use_fwd", 1,0,1,{3'd5,3'd4},2'b01,1,3'd6,0,SD,0,4'b0011,32'hBBBB_3333);
    vec[12] = mk("str_reads",  1,0,1,{3'd5,3'd6},2'b01,0,3'd5,0,SD,0,4'b0001,32'hBBBB_1111);
    vec[13] = mk("no_wr_hit",  1,0,1,{3'd5,3'd5},2'b11,1,3'd5,1,SD,0,4'b0000,RF);
    vec[14] = mk("id_invalid", 0,0,0,{3'd5,3'd6},2'b11,0,3'd0,0,SD,0,4'b0000,RF);
    vec[15] = mk("pre_flush",  0,0,1,{3'd5,3'd6},2'b11,0,3'd0,0,SD,1,4'b0011,32'hBBBB_3333);
    vec[16] = mk("flush",      1,1,1,{3'd5,3'd6},2'b11,0,3'd0,0,SD,0,4'b0011,32'hBBBB_3333);
    vec[17] = mk("post_flush", 1,0,1,{3'd5,3'd6},2'b11,0,3'd0,0,SD,0,4'b0000,RF);

    // Outputs while held in reset.
    drive(1,0,1,{3'd2,3'd1},2'b11,0,3'd0,0,SD);
    repeat (2) @(negedge clk);
    chk_out("in_reset", 0, 4'b0000, RF);
    rst_n = 1'b1;

    foreach (vec[n]) begin
      @(negedge clk);
      drive(vec[n].adv, vec[n].fl, vec[n].vld, vec[n].src, vec[n].used,
            vec[n].wr, vec[n].dest, vec[n].ld, vec[n].sd);
      #1;
      chk_out(vec[n].nm, vec[n].exp_stall, vec[n].exp_sel, vec[n].exp_opnd);
    end

    // Asynchronous reset with a live entry: ADD R1 in EX, then reset mid-cycle.
    @(negedge clk);
    drive(1,0,1,{3'd2,3'd1},2'b00,1,3'd1,0,SD);
    @(negedge clk);
    drive(0,0,1,{3'd2,3'd1},2'b11,0,3'd0,0,SD);
    #1;
    chk_out("pre_rst", 0, 4'b0001, 32'hBBBB_1111);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 0, 4'b0000, RF);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_out("post_rst", 0, 4'b0000, RF);

`ifdef FWD_HAZARD_STATS_EN
    chk("fwd_cnt_rst", {48'd0, bus.fwd_count}, 64'd0);
    chk("stall_cnt_rst", {48'd0, bus.stall_count}, 64'd0);
    @(negedge clk);
    drive(1,0,1,{3'd0,3'd1},2'b00,1,3'd1,0,SD);
    repeat (3) begin
      @(negedge clk);
      drive(1,0,1,{3'd0,3'd1},2'b01,1,3'd1,0,SD);
    end
    @(negedge clk);
    drive(1,0,1,{3'd0,3'd1},2'b00,1,3'd2,1,SD);
    repeat (2) begin
      @(negedge clk);
      drive(1,0,1,{3'd0,3'd2},2'b01,0,3'd0,0,SD);
    end
    @(negedge clk);
    drive(0,0,0,{3'd0,3'd0},2'b00,0,3'd0,0,SD);
    #1;
    chk("fwd_count", {48'd0, bus.fwd_count}, 64'd3);
    chk("stall_count", {48'd0, bus.stall_count}, 64'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
